// File: rtl/spi_pkg.sv
// Shared definitions for the configurable SPI master: FSM states, mode encodings
// and a width helper that never returns zero.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   // {cpol, cpha}
   localparam logic [1:0] SPI_MODE0 = 2'b00;
   localparam logic [1:0] SPI_MODE1 = 2'b01;
   localparam logic [1:0] SPI_MODE2 = 2'b10;
   localparam logic [1:0] SPI_MODE3 = 2'b11;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK generator: divides clk into half-periods while enabled and flags the
// leading/trailing SCLK edges; parks sclk at the idle level when disabled.
module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic idle_lvl,
   output logic sclk,
   output logic lead,
   output logic trail,
   output logic last
);

   localparam int DIV_W  = clog2_min1(CLK_DIV);
   localparam int HALF_W = clog2_min1(2 * DATA_W);

   logic [DIV_W-1:0]  div_cnt_reg;
   logic [HALF_W-1:0] half_cnt_reg;
   logic              sclk_reg;
   logic              tick;

   // A strobe marks the final clk of a half-period; sclk toggles on that edge.
   assign tick  = en && (div_cnt_reg == DIV_W'(CLK_DIV - 1));
   assign lead  = tick && !half_cnt_reg[0];
   assign trail = tick && half_cnt_reg[0];
   assign last  = tick && (half_cnt_reg == HALF_W'(2 * DATA_W - 1));
   assign sclk  = sclk_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_reg  <= '0;
         half_cnt_reg <= '0;
         sclk_reg     <= 1'b0;
      end else if (!en) begin
         div_cnt_reg  <= '0;
         half_cnt_reg <= '0;
         sclk_reg     <= idle_lvl;
      end else if (tick) begin
         div_cnt_reg  <= '0;
         half_cnt_reg <= half_cnt_reg + HALF_W'(1);
         sclk_reg     <= ~sclk_reg;
      end else begin
         div_cnt_reg  <= div_cnt_reg + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, runtime CPOL/CPHA, SCLK divider, one-hot
// chip selects and bit order, fed through a valid/ready transmit handshake.
module spi_master_cfg
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_CS    = 4,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [DATA_W-1:0]             tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic                          cpol,
   input  logic                          cpha,
   input  logic [clog2_min1(NUM_CS)-1:0] cs_sel,
   output logic [DATA_W-1:0]             rx_data,
   output logic                          rx_valid,
   output logic                          busy,
   output logic                          sclk,
   output logic                          mosi,
   input  logic                          miso,
   output logic [NUM_CS-1:0]             cs_n
);

   localparam int CS_W  = clog2_min1(NUM_CS);
   localparam int CNT_W = clog2_min1(CLK_DIV + 1);

   spi_state_t        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [DATA_W-1:0] tx_shift_reg;
   logic [DATA_W-1:0] rx_shift_reg;
   logic [DATA_W-1:0] rx_data_reg;
   logic              rx_valid_reg;
   logic              tx_ready_reg;
   logic              busy_reg;
   logic              mosi_reg;
   logic [NUM_CS-1:0] cs_n_reg;
   logic              cpol_reg;
   logic              cpha_reg;
   logic [CS_W-1:0]   sel_reg;

   logic [NUM_CS-1:0] cs_dec;
   logic              tx_bit;
   logic [DATA_W-1:0] tx_shift_next;
   logic [DATA_W-1:0] rx_shift_next;
   logic              xfer_en;
   logic              lead;
   logic              trail;
   logic              last;
   logic              sample_now;
   logic              shift_now;

   genvar gi;
   generate
      // An out-of-range index matches no select, so the word runs with all cs_n high.
      for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
         assign cs_dec[gi] = (sel_reg == CS_W'(gi));
      end

      if (MSB_FIRST != 0) begin : g_msb_first
         assign tx_bit        = tx_shift_reg[DATA_W-1];
         assign tx_shift_next = {tx_shift_reg[DATA_W-2:0], 1'b0};
         assign rx_shift_next = {rx_shift_reg[DATA_W-2:0], miso};
      end else begin : g_lsb_first
         assign tx_bit        = tx_shift_reg[0];
         assign tx_shift_next = {1'b0, tx_shift_reg[DATA_W-1:1]};
         assign rx_shift_next = {miso, rx_shift_reg[DATA_W-1:1]};
      end
   endgenerate

   assign xfer_en    = (state_reg == XFER);
   assign sample_now = cpha_reg ? trail : lead;
   assign shift_now  = cpha_reg ? lead : trail;

   spi_clk_gen #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk      (clk),
      .reset    (reset),
      .en       (xfer_en),
      .idle_lvl (cpol_reg),
      .sclk     (sclk),
      .lead     (lead),
      .trail    (trail),
      .last     (last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         tx_shift_reg <= '0;
         rx_shift_reg <= '0;
         rx_data_reg  <= '0;
         rx_valid_reg <= 1'b0;
         tx_ready_reg <= 1'b0;
         busy_reg     <= 1'b0;
         mosi_reg     <= 1'b0;
         cs_n_reg     <= {NUM_CS{1'b1}};
         cpol_reg     <= 1'b0;
         cpha_reg     <= 1'b0;
         sel_reg      <= '0;
      end else begin
         rx_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (tx_valid && tx_ready_reg) begin
                  tx_shift_reg <= tx_data;
                  cpol_reg     <= cpol;
                  cpha_reg     <= cpha;
                  sel_reg      <= cs_sel;
                  tx_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  cnt_reg      <= '0;
                  state_reg    <= SETUP;
               end else begin
                  tx_ready_reg <= 1'b1;
               end
            end
            SETUP: begin
               // The first SETUP clk only captures the accepted word, so selects
               // and the cpha=0 first bit appear one clk after accept.
               cs_n_reg <= ~cs_dec;
               if (cnt_reg == '0 && !cpha_reg) begin
                  mosi_reg     <= tx_bit;
                  tx_shift_reg <= tx_shift_next;
               end
               if (cnt_reg == CNT_W'(CLK_DIV)) begin
                  cnt_reg   <= '0;
                  state_reg <= XFER;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            XFER: begin
               if (sample_now) begin
                  rx_shift_reg <= rx_shift_next;
               end
               if (shift_now) begin
                  mosi_reg     <= tx_bit;
                  tx_shift_reg <= tx_shift_next;
               end
               if (last) begin
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               if (cnt_reg == CNT_W'(CLK_DIV - 1)) begin
                  cs_n_reg     <= {NUM_CS{1'b1}};
                  rx_data_reg  <= rx_shift_reg;
                  rx_valid_reg <= 1'b1;
                  busy_reg     <= 1'b0;
                  tx_ready_reg <= 1'b1;
                  cnt_reg      <= '0;
                  state_reg    <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign tx_ready = tx_ready_reg;
   assign rx_data  = rx_data_reg;
   assign rx_valid = rx_valid_reg;
   assign busy     = busy_reg;
   assign mosi     = mosi_reg;
   assign cs_n     = cs_n_reg;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: vector table, random words against a behavioural SPI
// slave, back-to-back, reset abort and an LSB-first 16-bit instance.
module tb_spi_master_cfg;
   import spi_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       cpol = 1'b0;
   logic       cpha = 1'b0;
   logic [1:0] cs_sel = 2'd0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic [3:0] cs_n;

   logic [15:0] tx_data6 = 16'h0000;
   logic        tx_valid6 = 1'b0;
   logic        tx_ready6;
   logic        cpol6 = 1'b0;
   logic        cpha6 = 1'b0;
   logic [1:0]  cs_sel6 = 2'd0;
   logic [15:0] rx_data6;
   logic        rx_valid6;
   logic        busy6;
   logic        sclk6;
   logic        mosi6;
   logic        miso6;
   logic [3:0]  cs_n6;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   spi_master_cfg dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel), .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
   );

   spi_master_cfg #(.DATA_W(16), .NUM_CS(4), .CLK_DIV(1), .MSB_FIRST(0)) dut6 (
      .clk(clk), .reset(reset), .tx_data(tx_data6), .tx_valid(tx_valid6), .tx_ready(tx_ready6),
      .cpol(cpol6), .cpha(cpha6), .cs_sel(cs_sel6), .rx_data(rx_data6), .rx_valid(rx_valid6),
      .busy(busy6), .sclk(sclk6), .mosi(mosi6), .miso(miso6), .cs_n(cs_n6)
   );

   assign miso6 = mosi6;

   // Behavioural MSB-first slave: samples and drives on SCLK edges chosen by the
   // mode rules, observed once per clk on the falling edge.
   logic [1:0] s_mode = 2'b00;
   logic [7:0] s_word = 8'h00;
   logic [7:0] s_rx = 8'h00;
   int         s_samples = 0;
   int         s_rises = 0;
   int         s_k = 0;
   logic       s_miso = 1'b0;
   logic       s_prev_cs = 1'b0;
   logic       s_prev_sclk = 1'b0;
   logic       s_act;
   logic       s_lead;
   bit         lp = 1'b0;

   assign miso = lp ? mosi : s_miso;

   always @(negedge clk) begin
      s_act = (cs_n != 4'hF);
      if (s_act && !s_prev_cs) begin
         s_rx = 8'h00;
         s_samples = 0;
         s_rises = 0;
         s_k = 0;
         if (!s_mode[0]) begin
            s_miso = s_word[7];
            s_k = 1;
         end
      end else if (s_act && sclk != s_prev_sclk) begin
         s_lead = (s_prev_sclk == s_mode[1]);
         if (sclk) s_rises++;
         if (s_lead == !s_mode[0]) begin
            s_rx = {s_rx[6:0], mosi};
            s_samples++;
         end else begin
            s_miso = (s_k < 8) ? s_word[3'(7 - s_k)] : 1'b0;
            s_k++;
         end
      end
      s_prev_cs = s_act;
      s_prev_sclk = sclk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [1:0] mode,
                           input logic [1:0] sel, input logic [7:0] sw, input bit loop,
                           input logic [7:0] exp_rx, input logic [3:0] exp_cs);
      int cyc;
      int low_cnt;
      int guard;
      bit cs_bad;
      s_word = sw;
      s_mode = mode;
      lp = loop;
      guard = 0;
      while (!tx_ready && guard < 10) begin
         tick;
         guard++;
      end
      check({tag, "_ready"}, 32'(tx_ready), 32'd1);
      tx_data = tx;
      cpol = mode[1];
      cpha = mode[0];
      cs_sel = sel;
      tx_valid = 1'b1;
      tick;
      // Scramble inputs: they must be ignored while busy.
      tx_valid = 1'b0;
      tx_data = 8'($urandom);
      {cpol, cpha} = 2'($urandom);
      cs_sel = 2'($urandom);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_ready_low"}, 32'(tx_ready), 32'd0);
      cyc = 0;
      low_cnt = 0;
      cs_bad = 1'b0;
      while (!rx_valid && cyc < 200) begin
         if (cs_n == exp_cs) low_cnt++;
         else if (cs_n != 4'hF) cs_bad = 1'b1;
         tick;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd73);
      check({tag, "_cs_low_cycles"}, 32'(low_cnt), 32'd72);
      check({tag, "_cs_other"}, 32'(cs_bad), 32'd0);
      check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
      check({tag, "_slave_rx"}, 32'(s_rx), 32'(tx));
      check({tag, "_samples"}, 32'(s_samples), 32'd8);
      check({tag, "_sclk_rises"}, 32'(s_rises), 32'd8);
      check({tag, "_cs_end"}, 32'(cs_n), 32'hF);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_sclk_idle"}, 32'(sclk), 32'(mode[1]));
      tick;
      check({tag, "_rx_valid_pulse"}, 32'(rx_valid), 32'd0);
      check({tag, "_rx_hold"}, 32'(rx_data), 32'(exp_rx));
      $display("xfer %s mode=%0d sel=%0d tx=%02h rx=%02h slave_rx=%02h lat=%0d", tag, mode, sel, tx,
               rx_data, s_rx, cyc);
   endtask

   task automatic run6(input string tag, input logic [15:0] tx, input logic [1:0] mode);
      int cyc;
      int guard;
      logic fb;
      logic [3:0] cs1;
      guard = 0;
      while (!tx_ready6 && guard < 10) begin
         tick;
         guard++;
      end
      tx_data6 = tx;
      cpol6 = mode[1];
      cpha6 = mode[0];
      cs_sel6 = 2'd0;
      tx_valid6 = 1'b1;
      tick;
      tx_valid6 = 1'b0;
      check({tag, "_busy"}, 32'(busy6), 32'd1);
      cyc = 0;
      fb = 1'bx;
      cs1 = 4'hx;
      while (!rx_valid6 && cyc < 100) begin
         if (cyc == 1) begin
            fb = mosi6;
            cs1 = cs_n6;
         end
         tick;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'd35);
      check({tag, "_rx_data"}, 32'(rx_data6), 32'(tx));
      check({tag, "_cs"}, 32'(cs1), 32'hE);
      check({tag, "_sclk_idle"}, 32'(sclk6), 32'(mode[1]));
      if (!mode[0]) check({tag, "_first_bit"}, 32'(fb), 32'(tx[0]));
      $display("xfer %s mode=%0d tx=%04h rx=%04h lat=%0d", tag, mode, tx, rx_data6, cyc);
   endtask

   typedef struct {
      logic [7:0] tx;
      logic [1:0] mode;
      logic [1:0] sel;
      logic [7:0] sw;
      bit         loop;
      logic [7:0] exp_rx;
      logic [3:0] exp_cs;
   } vec_t;

   vec_t tbl [5];
   int   cyc;
   int   first;
   int   second;
   int   pulses;
   int   gap;
   int   rx_seen;
   logic [7:0] rx1;
   logic [7:0] rx2;
   logic [7:0] rtx;
   logic [7:0] rsw;
   logic [1:0] rmode;
   logic [1:0] rsel;

   initial begin
      tbl[0] = '{8'hA5, SPI_MODE0, 2'd0, 8'h00, 1'b1, 8'hA5, 4'b1110};
      tbl[1] = '{8'h3C, SPI_MODE3, 2'd0, 8'hC3, 1'b0, 8'hC3, 4'b1110};
      tbl[2] = '{8'h69, SPI_MODE1, 2'd2, 8'h96, 1'b0, 8'h96, 4'b1011};
      tbl[3] = '{8'hF0, SPI_MODE2, 2'd1, 8'h0F, 1'b0, 8'h0F, 4'b1101};
      tbl[4] = '{8'h81, SPI_MODE1, 2'd3, 8'h7E, 1'b0, 8'h7E, 4'b0111};

      // Reset state
      repeat (3) tick;
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'hF);
      reset = 1'b0;
      check("rst_ready_before_clk", 32'(tx_ready), 32'd0);
      tick;
      check("rst_ready_after_clk", 32'(tx_ready), 32'd1);

      for (int i = 0; i < 5; i++) begin
         run_xfer($sformatf("vec%0d", i), tbl[i].tx, tbl[i].mode, tbl[i].sel, tbl[i].sw,
                  tbl[i].loop, tbl[i].exp_rx, tbl[i].exp_cs);
      end

      // Random words: the slave must return its word and capture ours.
      for (int i = 0; i < 8; i++) begin
         rtx = 8'($urandom);
         rsw = 8'($urandom);
         rmode = 2'($urandom_range(0, 3));
         rsel = 2'($urandom_range(0, 3));
         run_xfer($sformatf("rnd%0d", i), rtx, rmode, rsel, rsw, 1'b0, rsw, ~(4'b0001 << rsel));
      end

      // Back-to-back words with tx_valid held
      lp = 1'b1;
      s_mode = SPI_MODE0;
      tx_data = 8'h01;
      cpol = 1'b0;
      cpha = 1'b0;
      cs_sel = 2'd0;
      tx_valid = 1'b1;
      tick;
      tx_data = 8'h80;
      cyc = 0;
      first = -1;
      second = -1;
      pulses = 0;
      gap = 0;
      rx1 = 8'h00;
      rx2 = 8'h00;
      while (second < 0 && cyc < 400) begin
         if (rx_valid) begin
            pulses++;
            if (first < 0) begin
               first = cyc;
               rx1 = rx_data;
            end else begin
               second = cyc;
               rx2 = rx_data;
            end
         end
         if (first >= 0 && cyc <= first + 2 && cs_n == 4'hF) gap++;
         if (first >= 0 && cyc == first + 1) begin
            check("b2b_second_accept", 32'(busy), 32'd1);
            tx_valid = 1'b0;
         end
         tick;
         cyc++;
      end
      tx_valid = 1'b0;
      check("b2b_first_latency", 32'(first), 32'd73);
      check("b2b_second_latency", 32'(second), 32'd147);
      check("b2b_rx1", 32'(rx1), 32'h01);
      check("b2b_rx2", 32'(rx2), 32'h80);
      check("b2b_cs_gap", 32'(gap >= 1), 32'd1);
      tick;
      check("b2b_rx_valid_end", 32'(rx_valid), 32'd0);
      check("b2b_pulses", 32'(pulses), 32'd2);
      $display("xfer b2b rx1=%02h rx2=%02h at %0d/%0d", rx1, rx2, first, second);

      // Reset in the middle of a transfer
      tx_data = 8'hC7;
      cs_sel = 2'd1;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      repeat (30) tick;
      reset = 1'b1;
      #1;
      check("abort_cs_n", 32'(cs_n), 32'hF);
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rx_valid", 32'(rx_valid), 32'd0);
      check("abort_tx_ready", 32'(tx_ready), 32'd0);
      tick;
      tick;
      reset = 1'b0;
      tick;
      check("abort_ready_after", 32'(tx_ready), 32'd1);
      rx_seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (rx_valid) rx_seen++;
         tick;
      end
      check("abort_no_rx_valid", 32'(rx_seen), 32'd0);
      $display("xfer abort at cycle 30 rx_valid_seen=%0d", rx_seen);
      run_xfer("after_abort", 8'h5A, SPI_MODE0, 2'd0, 8'h00, 1'b1, 8'h5A, 4'b1110);

      // LSB-first, 16-bit, CLK_DIV=1 instance
      run6("w16_first", 16'h0001, SPI_MODE0);
      for (int i = 0; i < 4; i++) begin
         run6($sformatf("w16_rnd%0d", i), 16'($urandom), 2'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
